// File: rtl/fifo_drain_tx.sv
// Drains a synchronous FIFO with one-cycle read latency onto a valid/ready stream.
// A small ring buffer absorbs the read latency so the stream sustains one beat per cycle.
module fifo_drain_tx #(
   parameter int unsigned width = 32,
   parameter int unsigned depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             fifo_empty_i,
   output logic             fifo_read_o,
   input  logic [width-1:0] fifo_data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [width-1:0] data_o,
   output logic [31:0]      xfer_cnt_o
);

   localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned occ_w = $clog2(depth + 2);

   logic [occ_w-1:0] occ_q, occ_d, occ_after;
   logic             inflight_q;
   logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             pop;
   logic [width-1:0] buf_q [depth];

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
   endfunction

   assign valid_o    = (occ_q != '0);
   assign data_o     = valid_o ? buf_q[rd_ptr_q] : '0;
   assign xfer_cnt_o = cnt_q;

   // Next-state: a read is issued only if the returning entry is guaranteed a free slot.
   always_comb begin
      pop         = 1'b0;
      occ_after   = occ_q;
      occ_d       = occ_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      fifo_read_o = 1'b0;

      pop         = valid_o & ready_i;
      occ_after   = occ_q + occ_w'(inflight_q) - occ_w'(pop);
      fifo_read_o = rst_i & enable_i & ~fifo_empty_i & (occ_after < occ_w'(depth));
      occ_d       = occ_after;
      if (inflight_q) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         cnt_d    = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_read_o;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Buffer storage needs no reset; occupancy alone qualifies its contents.
   always_ff @(posedge clk_i) begin
      if (inflight_q) buf_q[wr_ptr_q] <= fifo_data_i;
   end

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Bench for fifo_drain_tx: behavioural FIFO source, scoreboard of pushed entries,
// and per-scenario tasks for reset, streaming, backpressure, enable gating and random traffic.
`timescale 1ns/1ps
module tb_fifo_drain_tx;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 3;

   logic          clk_i;
   logic          rst_i;
   logic          enable_i;
   logic          fifo_empty_i;
   logic          fifo_read_o;
   logic [W-1:0]  fifo_data_i;
   logic          valid_o;
   logic          ready_i;
   logic [W-1:0]  data_o;
   logic [31:0]   xfer_cnt_o;

   int            vectors;
   int            fails;
   logic [W-1:0]  fifo_q [$];
   logic [W-1:0]  exp_q  [$];
   int            wr_total;
   int            rd_total;
   int            reads;
   int            pops;
   int            sent;
   bit            rd_s;
   bit            hold_v;
   logic [W-1:0]  hold_d;

   fifo_drain_tx #(.width(W), .depth(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .fifo_empty_i(fifo_empty_i),
      .fifo_read_o (fifo_read_o),
      .fifo_data_i (fifo_data_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .xfer_cnt_o  (xfer_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   assign fifo_empty_i = (wr_total == rd_total);

   // Source FIFO: a strobe seen in a cycle pops at the following edge; data valid the next cycle.
   always @(posedge clk_i) begin
      if (rst_i && rd_s && fifo_q.size() != 0) begin
         fifo_data_i <= fifo_q.pop_front();
         rd_total    <= rd_total + 1;
      end
   end

   // Stream monitor sampled mid-cycle, when all combinational outputs have settled.
   always @(negedge clk_i) begin
      logic [W-1:0] e;
      rd_s = rst_i & fifo_read_o;
      if (rst_i) begin
         vectors++;
         if (fifo_read_o && fifo_empty_i) begin
            fails++;
            $display("FAIL read_when_empty: fifo_read_o=%b with fifo_empty_i=1 at %0t", fifo_read_o, $time);
         end
         if (hold_v) begin
            vectors++;
            if (valid_o !== 1'b1 || data_o !== hold_d) begin
               fails++;
               $display("FAIL stream_hold: valid=%b data=%h, required valid=1 data=%h", valid_o, data_o, hold_d);
            end
         end
         if (valid_o && ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_xfer: data=%h, required no transfer", data_o);
            end else begin
               e = exp_q.pop_front();
               if (data_o !== e) begin
                  fails++;
                  $display("FAIL xfer_data: got %h, required %h", data_o, e);
               end
            end
            pops++;
         end
         if (rd_s) reads++;
         vectors++;
         if (reads - pops > int'(DEPTH)) begin
            fails++;
            $display("FAIL occupancy: outstanding %0d, required <= %0d", reads - pops, DEPTH);
         end
         hold_v = valid_o & ~ready_i;
         hold_d = data_o;
      end else begin
         hold_v = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [W-1:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
      wr_total++;
      sent++;
   endtask

   task automatic apply_reset();
      rst_i = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      wr_total = rd_total;
      reads = 0;
      pops  = 0;
      sent  = 0;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while (n < budget && exp_q.size() != 0) begin
         step();
         n++;
      end
      step();
      vectors++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain_timeout: %0d entries left, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      apply_reset();
      enable_i = 1'b1;
      ready_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fifo_q.push_back(W'(32'hDEAD_0000 + i));
         wr_total++;
      end
      repeat (3) step();
      vectors += 4;
      if (valid_o !== 1'b0)      begin fails++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
      if (fifo_read_o !== 1'b0)  begin fails++; $display("FAIL reset_read: got %b, required 0", fifo_read_o); end
      if (xfer_cnt_o !== 32'd0)  begin fails++; $display("FAIL reset_cnt: got %0d, required 0", xfer_cnt_o); end
      if (data_o !== '0)         begin fails++; $display("FAIL reset_data: got %h, required 0", data_o); end
      fifo_q.delete();
      wr_total = rd_total;
      enable_i = 1'b0;
      step();
      rst_i = 1'b1;
   endtask

   task automatic test_stream();
      step();
      enable_i = 1'b0;
      ready_i  = 1'b1;
      for (int i = 1; i <= 16; i++) push(W'(i));
      step();
      enable_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         vectors += 2;
         if (valid_o !== (k >= 2 && k <= 17)) begin
            fails++;
            $display("FAIL stream_valid[%0d]: got %b, required %b", k, valid_o, (k >= 2 && k <= 17));
         end
         if (fifo_read_o !== (k < 16)) begin
            fails++;
            $display("FAIL stream_read[%0d]: got %b, required %b", k, fifo_read_o, (k < 16));
         end
      end
      vectors++;
      if (xfer_cnt_o !== 32'd16) begin
         fails++;
         $display("FAIL stream_cnt: got %0d, required 16", xfer_cnt_o);
      end
   endtask

   task automatic test_backpressure();
      int r0;
      step();
      ready_i  = 1'b0;
      enable_i = 1'b0;
      for (int i = 0; i < 8; i++) push(W'(32'h100 + i));
      step();
      enable_i = 1'b1;
      r0 = reads;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         if (k >= 2) begin
            vectors++;
            if (valid_o !== 1'b1 || data_o !== W'(32'h100)) begin
               fails++;
               $display("FAIL bp_hold[%0d]: valid=%b data=%h, required valid=1 data=100", k, valid_o, data_o);
            end
         end
      end
      vectors++;
      if (reads - r0 != int'(DEPTH)) begin
         fails++;
         $display("FAIL bp_reads: got %0d, required %0d", reads - r0, DEPTH);
      end
      step();
      ready_i = 1'b1;
      wait_drain(100, "bp");
      vectors++;
      if (xfer_cnt_o !== 32'(sent)) begin
         fails++;
         $display("FAIL bp_cnt: got %0d, required %0d", xfer_cnt_o, sent);
      end
   endtask

   task automatic test_enable();
      int r0;
      int p0;
      step();
      enable_i = 1'b0;
      ready_i  = 1'b1;
      for (int i = 0; i < 4; i++) push(W'(32'h200 + i));
      step();
      r0 = reads;
      p0 = pops;
      enable_i = 1'b1;
      step();
      enable_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         vectors++;
         if (fifo_read_o !== 1'b0) begin
            fails++;
            $display("FAIL en_gate[%0d]: fifo_read_o=%b, required 0", k, fifo_read_o);
         end
      end
      vectors += 2;
      if (reads - r0 != 1) begin
         fails++;
         $display("FAIL en_reads: got %0d, required 1", reads - r0);
      end
      if (pops - p0 != 1) begin
         fails++;
         $display("FAIL en_inflight_delivered: got %0d, required 1", pops - p0);
      end
      step();
      enable_i = 1'b1;
      wait_drain(100, "en");
      vectors++;
      if (xfer_cnt_o !== 32'(sent)) begin
         fails++;
         $display("FAIL en_cnt: got %0d, required %0d", xfer_cnt_o, sent);
      end
   endtask

   task automatic test_random();
      int target;
      int n;
      target = sent + 10000;
      enable_i = 1'b1;
      n = 0;
      while (sent < target && n < 60000) begin
         step();
         ready_i = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) push(W'($urandom));
         n++;
      end
      step();
      ready_i = 1'b1;
      wait_drain(200, "rand");
      vectors++;
      if (xfer_cnt_o !== 32'(sent)) begin
         fails++;
         $display("FAIL rand_cnt: got %0d, required %0d", xfer_cnt_o, sent);
      end
   endtask

   task automatic test_reset_mid();
      step();
      ready_i  = 1'b0;
      enable_i = 1'b0;
      for (int i = 0; i < 5; i++) push(W'(32'h300 + i));
      step();
      enable_i = 1'b1;
      repeat (3) step();
      vectors++;
      if (valid_o !== 1'b1 || data_o !== W'(32'h300)) begin
         fails++;
         $display("FAIL mid_pre: valid=%b data=%h, required valid=1 data=300", valid_o, data_o);
      end
      apply_reset();
      #1;
      vectors += 4;
      if (valid_o !== 1'b0)     begin fails++; $display("FAIL mid_valid: got %b, required 0", valid_o); end
      if (fifo_read_o !== 1'b0) begin fails++; $display("FAIL mid_read: got %b, required 0", fifo_read_o); end
      if (data_o !== '0)        begin fails++; $display("FAIL mid_data: got %h, required 0", data_o); end
      if (xfer_cnt_o !== 32'd0) begin fails++; $display("FAIL mid_cnt0: got %0d, required 0", xfer_cnt_o); end
      step();
      step();
      rst_i   = 1'b1;
      ready_i = 1'b1;
      push(W'(32'hA));
      push(W'(32'hB));
      wait_drain(50, "mid");
      repeat (2) step();
      vectors++;
      if (xfer_cnt_o !== 32'd2) begin
         fails++;
         $display("FAIL mid_cnt: got %0d, required 2", xfer_cnt_o);
      end
   endtask

   initial begin
      vectors     = 0;
      fails       = 0;
      wr_total    = 0;
      rd_total    = 0;
      reads       = 0;
      pops        = 0;
      sent        = 0;
      rd_s        = 1'b0;
      hold_v      = 1'b0;
      hold_d      = '0;
      rst_i       = 1'b0;
      enable_i    = 1'b0;
      ready_i     = 1'b0;
      fifo_data_i = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_enable();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
